// File: rtl/rvc_fetch_align.sv
// rvc_fetch_align: parcel FIFO that realigns fetch words into RV32 instructions, expanding RVC.
// Rev 1.0
`default_nettype none

module rvc_fetch_align #(
  parameter int unsigned FETCH_W  = 32,
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_valid,
  output logic                      fetch_ready,
  input  logic [FETCH_W-1:0]        fetch_data,
  input  logic                      flush,
  input  logic [31:0]               flush_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [31:0]               instr_o,
  output logic                      instr_is_c,
  output logic [31:0]               instr_pc,
  output logic [$clog2(DEPTH):0]    buf_count
);

  localparam int unsigned P  = FETCH_W / 16;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = $clog2(P);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // RV32C to RV32I expansion; reserved and unsupported encodings yield 32'h0 (illegal).
  function automatic logic [31:0] rvc_expand(input logic [15:0] c);
    logic [31:0] r;
    logic [4:0]  rdp;
    logic [4:0]  rs2p;
    rdp  = {2'b01, c[9:7]};
    rs2p = {2'b01, c[4:2]};
    r    = 32'h0;
    case ({c[1:0], c[15:13]})
      5'b00_000: if (c[12:5] != 8'h0)
        r = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rs2p, OP_IMM};
      5'b00_010: r = {5'b0, c[5], c[12:10], c[6], 2'b00, rdp, 3'b010, rs2p, OP_LD};
      5'b00_110: r = {5'b0, c[5], c[12], rs2p, rdp, 3'b010, c[11:10], c[6], 2'b00, OP_ST};
      5'b01_000: r = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], OP_IMM};
      5'b01_001, 5'b01_101:
        r = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}},
             (c[15] ? 5'd0 : 5'd1), OP_JAL};
      5'b01_010: r = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, c[11:7], OP_IMM};
      5'b01_011: begin
        if (c[11:7] == 5'd2) begin
          if ({c[12], c[6:2]} != 6'h0)
            r = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
        end else if ({c[12], c[6:2]} != 6'h0) begin
          r = {{14{c[12]}}, c[12], c[6:2], c[11:7], OP_LUI};
        end
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00, 2'b01: if (!c[12])
            r = {1'b0, c[10], 5'b0, c[6:2], rdp, 3'b101, rdp, OP_IMM};
          2'b10: r = {{6{c[12]}}, c[12], c[6:2], rdp, 3'b111, rdp, OP_IMM};
          default: if (!c[12]) begin
            case (c[6:5])
              2'b00:   r = {7'b0100000, rs2p, rdp, 3'b000, rdp, OP_REG};
              2'b01:   r = {7'b0000000, rs2p, rdp, 3'b100, rdp, OP_REG};
              2'b10:   r = {7'b0000000, rs2p, rdp, 3'b110, rdp, OP_REG};
              default: r = {7'b0000000, rs2p, rdp, 3'b111, rdp, OP_REG};
            endcase
          end
        endcase
      end
      5'b01_110, 5'b01_111:
        r = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rdp, 2'b00, c[13], c[11:10], c[4:3],
             c[12], OP_BR};
      5'b10_000: if (!c[12]) r = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], OP_IMM};
      5'b10_010: if (c[11:7] != 5'd0)
        r = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], OP_LD};
      5'b10_100: begin
        if (!c[12]) begin
          if (c[6:2] == 5'd0) begin
            if (c[11:7] != 5'd0) r = {12'b0, c[11:7], 3'b000, 5'd0, OP_JR};
          end else begin
            r = {7'b0, c[6:2], 5'd0, 3'b000, c[11:7], OP_REG};
          end
        end else begin
          if (c[6:2] == 5'd0) begin
            if (c[11:7] == 5'd0) r = 32'h0010_0073;
            else                 r = {12'b0, c[11:7], 3'b000, 5'd1, OP_JR};
          end else begin
            r = {7'b0, c[6:2], c[11:7], 3'b000, c[11:7], OP_REG};
          end
        end
      end
      5'b10_110: r = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, OP_ST};
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

  logic [15:0]   buf_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic [DW-1:0] drop_q;

  logic [15:0]   parcel_in [P];
  logic [AW-1:0] wr_idx [P];
  logic [P-1:0]  wr_en;
  logic [AW-1:0] head_nx;
  logic [15:0]   p0, p1;
  logic          is16, avail, accept, consume;
  logic [CW-1:0] n_acc, n_con;

  // Parcels are halfword byte-swapped relative to the bus lane order.
  always_comb begin
    for (int k = 0; k < P; k++) begin
      parcel_in[k] = {fetch_data[16*k +: 8], fetch_data[16*k+8 +: 8]};
      wr_en[k]     = accept && (k >= int'(drop_q));
      wr_idx[k]    = tail_q + AW'(k) - AW'(drop_q);
    end
  end

  assign head_nx     = head_q + AW'(1);
  assign p0          = buf_q[head_q];
  assign p1          = buf_q[head_nx];
  assign is16        = (p0[1:0] != 2'b11);
  assign avail       = is16 ? (count_q != '0) : (count_q >= CW'(2));
  assign fetch_ready = (count_q <= CW'(DEPTH - P));
  assign accept      = fetch_valid && fetch_ready && !flush;
  assign consume     = avail && instr_ready && !flush;
  assign n_acc       = CW'(P) - CW'(drop_q);
  assign n_con       = is16 ? CW'(1) : CW'(2);

  always_comb begin
    count_d = count_q;
    tail_d  = tail_q;
    head_d  = head_q;
    pc_d    = pc_q;
    if (accept) begin
      count_d = count_d + n_acc;
      tail_d  = tail_q + AW'(P) - AW'(drop_q);
    end
    if (consume) begin
      count_d = count_d - n_con;
      head_d  = head_q + (is16 ? AW'(1) : AW'(2));
      pc_d    = pc_q + (is16 ? 32'd2 : 32'd4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      drop_q  <= RESET_PC[DW:1];
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= flush_pc;
      drop_q  <= flush_pc[DW:1];
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      if (accept) drop_q <= '0;
    end
  end

  // Storage needs no reset: nothing is read out unless count covers it.
  always_ff @(posedge clk) begin
    for (int k = 0; k < P; k++) begin
      if (wr_en[k]) buf_q[wr_idx[k]] <= parcel_in[k];
    end
  end

  assign instr_valid = avail;
  assign instr_is_c  = avail && is16;
  assign instr_o     = !avail ? 32'h0 : (is16 ? rvc_expand(p0) : {p1, p0});
  assign instr_pc    = pc_q;
  assign buf_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rvc_fetch_align.sv
// tb_rvc_fetch_align: directed vector bench for rvc_fetch_align (32-bit and 64-bit fetch widths).
// Rev 1.0
`default_nettype none

module tb_rvc_fetch_align;

  localparam logic [15:0] C_LI   = 16'h4515;  // c.li   x10, 5
  localparam logic [15:0] C_MV   = 16'h85AA;  // c.mv   x11, x10
  localparam logic [15:0] C_ADDI = 16'h157D;  // c.addi x10, -1
  localparam logic [15:0] C_ADD  = 16'h952E;  // c.add  x10, x11
  localparam logic [15:0] C_LW   = 16'h40C0;  // c.lw   x8, 4(x9)
  localparam logic [15:0] C_NOP  = 16'h0001;
  localparam logic [15:0] I_LO   = 16'hBEEF;
  localparam logic [15:0] I_HI   = 16'hDEAD;
  localparam logic [31:0] E_LI   = 32'h0050_0513;
  localparam logic [31:0] E_MV   = 32'h00A0_05B3;
  localparam logic [31:0] E_ADDI = 32'hFFF5_0513;
  localparam logic [31:0] E_ADD  = 32'h00B5_0533;
  localparam logic [31:0] E_LW   = 32'h0044_A403;
  localparam logic [31:0] E_NOP  = 32'h0000_0013;
  localparam logic [31:0] E_I32  = 32'hDEAD_BEEF;

  logic        clk, rst_n;
  logic        fv, fl, ir, fr, iv, ic;
  logic [31:0] fd, fpc, io, ipc;
  logic [3:0]  bc;
  logic        fv64, fl64, ir64, fr64, iv64, ic64;
  logic [63:0] fd64;
  logic [31:0] fpc64, io64, ipc64;
  logic [3:0]  bc64;

  int n_checks = 0;
  int n_errors = 0;

  rvc_fetch_align #(.FETCH_W(32), .DEPTH(8), .RESET_PC(32'h0)) dut32 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fv), .fetch_ready(fr), .fetch_data(fd),
    .flush(fl), .flush_pc(fpc), .instr_valid(iv), .instr_ready(ir), .instr_o(io),
    .instr_is_c(ic), .instr_pc(ipc), .buf_count(bc)
  );

  rvc_fetch_align #(.FETCH_W(64), .DEPTH(8), .RESET_PC(32'h6)) dut64 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fv64), .fetch_ready(fr64), .fetch_data(fd64),
    .flush(fl64), .flush_pc(fpc64), .instr_valid(iv64), .instr_ready(ir64), .instr_o(io64),
    .instr_is_c(ic64), .instr_pc(ipc64), .buf_count(bc64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] fd;
    logic        fl;
    logic [31:0] fpc;
    logic        ir;
    logic        ev;
    logic [31:0] ei;
    logic        ec;
    logic [31:0] epc;
    logic [3:0]  ecnt;
    logic        efr;
  } vec_t;

  vec_t vecs[$];

  // Parcel p at lower address goes in the low halfword, bytes swapped on the bus.
  function automatic logic [31:0] w32(input logic [15:0] p0, input logic [15:0] p1);
    return {p1[7:0], p1[15:8], p0[7:0], p0[15:8]};
  endfunction

  function automatic logic [63:0] w64(input logic [15:0] p0, input logic [15:0] p1,
                                      input logic [15:0] p2, input logic [15:0] p3);
    return {w32(p2, p3), w32(p0, p1)};
  endfunction

  task automatic add_vec(input logic v_fv, input logic [31:0] v_fd, input logic v_fl,
                         input logic [31:0] v_fpc, input logic v_ir, input logic v_ev,
                         input logic [31:0] v_ei, input logic v_ec, input logic [31:0] v_epc,
                         input logic [3:0] v_ecnt, input logic v_efr);
    vec_t v;
    v.fv = v_fv; v.fd = v_fd; v.fl = v_fl; v.fpc = v_fpc; v.ir = v_ir;
    v.ev = v_ev; v.ei = v_ei; v.ec = v_ec; v.epc = v_epc; v.ecnt = v_ecnt; v.efr = v_efr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input int s, input logic ev, input logic [31:0] ei, input logic ec,
                       input logic [31:0] epc, input logic [3:0] ecnt, input logic efr);
    chk("instr_valid", s, 32'(iv), 32'(ev));
    chk("instr_o",     s, io, ei);
    chk("instr_is_c",  s, 32'(ic), 32'(ec));
    chk("instr_pc",    s, ipc, epc);
    chk("buf_count",   s, 32'(bc), 32'(ecnt));
    chk("fetch_ready", s, 32'(fr), 32'(efr));
  endtask

  task automatic chk64(input int s, input logic ev, input logic [31:0] ei, input logic ec,
                       input logic [31:0] epc, input logic [3:0] ecnt, input logic efr);
    chk("w64 instr_valid", s, 32'(iv64), 32'(ev));
    chk("w64 instr_o",     s, io64, ei);
    chk("w64 instr_is_c",  s, 32'(ic64), 32'(ec));
    chk("w64 instr_pc",    s, ipc64, epc);
    chk("w64 buf_count",   s, 32'(bc64), 32'(ecnt));
    chk("w64 fetch_ready", s, 32'(fr64), 32'(efr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // fv, fd, fl, fpc, ir | valid, instr, is_c, pc, count, fetch_ready (before the edge)
    add_vec(1, w32(C_LI, C_MV),    0, 0, 1,  0, 0,      0, 32'h0,   0, 1);
    add_vec(1, w32(C_ADDI, C_ADD), 0, 0, 1,  1, E_LI,   1, 32'h0,   2, 1);
    add_vec(1, w32(C_LW, C_NOP),   0, 0, 1,  1, E_MV,   1, 32'h2,   3, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_ADDI, 1, 32'h4,   4, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_ADD,  1, 32'h6,   3, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_LW,   1, 32'h8,   2, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_NOP,  1, 32'hA,   1, 1);
    add_vec(0, 0,                  1, 0, 1,  0, 0,      0, 32'hC,   0, 1);
    // 32-bit instruction straddling two words, issued without a bubble
    add_vec(1, w32(C_LI, I_LO),    0, 0, 1,  0, 0,      0, 32'h0,   0, 1);
    add_vec(1, w32(I_HI, C_MV),    0, 0, 1,  1, E_LI,   1, 32'h0,   2, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_I32,  0, 32'h2,   3, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_MV,   1, 32'h6,   1, 1);
    // lone low half waits for its high half
    add_vec(1, w32(C_NOP, I_LO),   0, 0, 1,  0, 0,      0, 32'h8,   0, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_NOP,  1, 32'h8,   2, 1);
    add_vec(0, 0,                  0, 0, 1,  0, 0,      0, 32'hA,   1, 1);
    add_vec(0, 0,                  0, 0, 1,  0, 0,      0, 32'hA,   1, 1);
    add_vec(1, w32(I_HI, C_LI),    0, 0, 1,  0, 0,      0, 32'hA,   1, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_I32,  0, 32'hA,   3, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_LI,   1, 32'hE,   1, 1);
    // backpressure fills the buffer; output holds
    add_vec(1, w32(C_NOP, C_LI),   0, 0, 0,  0, 0,      0, 32'h10,  0, 1);
    add_vec(1, w32(C_MV, C_ADDI),  0, 0, 0,  1, E_NOP,  1, 32'h10,  2, 1);
    add_vec(1, w32(C_ADD, C_LW),   0, 0, 0,  1, E_NOP,  1, 32'h10,  4, 1);
    add_vec(1, w32(C_NOP, C_NOP),  0, 0, 0,  1, E_NOP,  1, 32'h10,  6, 1);
    add_vec(1, w32(C_LI, C_LI),    0, 0, 0,  1, E_NOP,  1, 32'h10,  8, 0);
    add_vec(1, w32(C_LI, C_LI),    0, 0, 0,  1, E_NOP,  1, 32'h10,  8, 0);
    add_vec(0, 0,                  0, 0, 1,  1, E_NOP,  1, 32'h10,  8, 0);
    add_vec(0, 0,                  0, 0, 1,  1, E_LI,   1, 32'h12,  7, 0);
    add_vec(0, 0,                  0, 0, 1,  1, E_MV,   1, 32'h14,  6, 1);
    // flush with count=5 beats the fetch word and the handshake
    add_vec(1, w32(C_NOP, C_NOP),  1, 32'h102, 1, 1, E_ADDI, 1, 32'h16, 5, 1);
    add_vec(1, w32(C_LI, C_MV),    0, 0, 1,  0, 0,      0, 32'h102, 0, 1);
    add_vec(0, 0,                  0, 0, 1,  1, E_MV,   1, 32'h102, 1, 1);
    add_vec(0, 0,                  0, 0, 1,  0, 0,      0, 32'h104, 0, 1);

    rst_n = 1'b0;
    fv = 0; fd = '0; fl = 0; fpc = '0; ir = 0;
    fv64 = 0; fd64 = '0; fl64 = 0; fpc64 = '0; ir64 = 0;
    #12;
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      fv = vecs[i].fv; fd = vecs[i].fd; fl = vecs[i].fl; fpc = vecs[i].fpc; ir = vecs[i].ir;
      #1;
      chk32(i, vecs[i].ev, vecs[i].ei, vecs[i].ec, vecs[i].epc, vecs[i].ecnt, vecs[i].efr);
      tick();
    end
    fv = 0; fl = 0; ir = 0;

    // Asynchronous reset in the middle of a cycle clears buffered parcels at once.
    fv = 1; fd = w32(C_LI, C_MV);
    tick();
    fv = 0;
    chk32(200, 1, E_LI, 1, 32'h104, 2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk32(201, 0, 0, 0, 32'h0, 0, 1);
    chk64(202, 0, 0, 0, 32'h6, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk32(203, 0, 0, 0, 32'h0, 0, 1);

    // 64-bit fetch: RESET_PC=6 drops three parcels of the first word.
    chk64(300, 0, 0, 0, 32'h6, 0, 1);
    fv64 = 1; fd64 = w64(C_NOP, C_NOP, C_NOP, C_LI); ir64 = 1;
    tick();
    fv64 = 0;
    chk64(301, 1, E_LI, 1, 32'h6, 1, 1);
    tick();
    chk64(302, 0, 0, 0, 32'h8, 0, 1);
    fl64 = 1; fpc64 = 32'h106; fv64 = 1; fd64 = w64(C_LI, C_LI, C_LI, C_LI);
    tick();
    fl64 = 0; fv64 = 0;
    chk64(303, 0, 0, 0, 32'h106, 0, 1);
    fv64 = 1; fd64 = w64(C_LI, C_LI, C_LI, C_MV); ir64 = 0;
    tick();
    chk64(304, 1, E_MV, 1, 32'h106, 1, 1);
    fd64 = w64(C_NOP, I_LO, I_HI, C_ADDI);
    tick();
    fv64 = 0;
    chk64(305, 1, E_MV, 1, 32'h106, 5, 0);
    ir64 = 1;
    tick();
    chk64(306, 1, E_NOP, 1, 32'h108, 4, 1);
    tick();
    chk64(307, 1, E_I32, 0, 32'h10A, 3, 1);
    tick();
    chk64(308, 1, E_ADDI, 1, 32'h10E, 1, 1);
    tick();
    chk64(309, 0, 0, 0, 32'h110, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
